multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the single-core RV32I datapath.
- Decodes the instruction register and steps the shared ALU through fetch, decode, execute, memory and writeback phases.
- Drives the ALU operand muxes, alu_op, register/PC/IR write enables and memory handshake, one phase per state.
- Flags unsupported encodings and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
instr  input  32  current IR contents (valid from DECODE onward)
zero  input  1  ALU zero flag
mem_ready  input  1  memory handshake: access completes this cycle
mem_req  output  1  memory access request
mem_we  output  1  memory write (valid with mem_req)
addr_sel  output  1  memory address: 0=PC, 1=ALUOut
ir_write  output  1  load IR from memory read data
pc_write  output  1  update PC
pc_src  output  1  PC source: 0=ALU result, 1=ALUOut register
reg_write  output  1  register file write enable
result_sel  output  1  writeback data: 0=ALUOut, 1=memory data
alu_src_a  output  2  ALU A: 0=PC, 1=oldPC, 2=rs1
alu_src_b  output  2  ALU B: 0=rs2, 1=imm, 2=constant 4
alu_op  output  alu_op_t  ALU_ADD/ALU_SUB/ALU_AND/ALU_PASS
retire  output  1  one-cycle pulse on instruction completion
instret  output  CNT_W  retired-instruction count
illegal  output  1  sticky unsupported-instruction flag

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, EXEC_LUI, BRANCH, JAL, ALUWB, TRAP. Next state registered.
- All outputs are decoded combinationally from the state (plus zero and mem_ready where stated). Outputs not listed for a state are 0; ALU outputs default to ADD with src 0/0.
- rst high: next edge forces state=FETCH, instret=0, illegal=0. While rst is high, mem_req, ir_write, pc_write, reg_write and retire are forced 0.
- FETCH: mem_req=1, addr_sel=0, ALU=PC+4 (src_a=0, src_b=2, ADD).
  - mem_ready=0: hold in FETCH.
  - mem_ready=1: ir_write=1, pc_write=1, pc_src=0, go to DECODE.
- DECODE: ALU=oldPC+imm (ADD, src_a=1, src_b=1); branch/jump target captured in ALUOut. Next state by opcode:
  - 0000011 (funct3 010) -> MEMADR
  - 0100011 (funct3 010) -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0110111 -> EXEC_LUI
  - 1100011 (funct3 000) -> BRANCH
  - 1101111 -> JAL
  - anything else -> TRAP
- MEMADR: rs1+imm ADD. LW -> MEMREAD; SW -> MEMWRITE.
- MEMREAD: mem_req=1, addr_sel=1. Hold until mem_ready=1, then -> MEMWB.
- MEMWB: reg_write=1, result_sel=1, retire; -> FETCH.
- MEMWRITE: mem_req=1, mem_we=1, addr_sel=1. Hold until mem_ready=1, then retire and -> FETCH.
- EXEC_R: src_a=2, src_b=0.
  - funct3=000/funct7=0000000 -> ADD; funct3=000/funct7=0100000 -> SUB; funct3=111/funct7=0000000 -> AND. Each -> ALUWB.
  - Any other funct3/funct7 -> TRAP.
- EXEC_I: src_a=2, src_b=1. funct3=000 -> ADD; funct3=111 -> AND; -> ALUWB. Other funct3 -> TRAP.
- EXEC_LUI: src_b=1, PASS -> ALUWB.
- BRANCH: rs1-rs2 (SUB, src_a=2, src_b=0). pc_write=zero, pc_src=1. retire; -> FETCH.
- JAL: ALU=oldPC+4 (src_a=1, src_b=2). pc_write=1, pc_src=1. -> ALUWB.
- ALUWB: reg_write=1, result_sel=0, retire; -> FETCH.
- TRAP: illegal=1, all enables 0, absorbing until rst.
- retire and the instret increment occur in the same cycle. instret wraps to 0 after all-ones.
- Latency with mem_ready tied 1: BEQ 3 cycles; SW, R, I, LUI and JAL 4 cycles; LW 5 cycles. Each cycle mem_ready stays low adds one cycle.
- rst asserted mid-instruction (including during a memory wait) aborts it with no retire; fetch restarts after rst deasserts.

Test Plan:
- Reset, mem_ready=1, instr=ADD x3,x1,x2 (0x002081B3) -> states FETCH, DECODE, EXEC_R(alu_op=ADD), ALUWB(reg_write=1); retire at cycle 4; instret=1.
- instr=LW x5,8(x1) (0x0080A283), mem_ready low 2 cycles in MEMREAD -> mem_req/addr_sel=1 held; MEMWB reg_write=1, result_sel=1 on cycle 7.
- BEQ (0x00208463) with zero=1, then again with zero=0 -> BRANCH alu_op=SUB; pc_write=1/pc_src=1 in the first case, pc_write=0 in the second; both retire.
- SUB (0x402081B3), ANDI (0x0FF0F093), LUI (0x123452B7) -> alu_op SUB, AND, PASS respectively in their execute states.
- instr=0xFFFFFFFF -> TRAP; illegal=1 held for 20 cycles; no mem_req; rst clears it and FETCH resumes.
- rst pulsed in MEMWRITE with mem_ready=0 -> no retire, no mem_we after the edge; instret=0; FETCH next.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Multi-cycle control FSM for a single-core RV32I datapath. It decodes the
// instruction register and steps a shared ALU through fetch, decode, execute,
// memory and writeback phases, one phase per state.
//
// Ports:
//   clk, rst              clock / synchronous active-high reset
//   instr                 instruction register contents (valid from DECODE)
//   zero                  ALU zero flag (branch resolution)
//   mem_ready             memory access completes this cycle
//   mem_req, mem_we       memory request / write strobe
//   addr_sel              memory address: 0=PC, 1=ALUOut
//   ir_write, pc_write    IR / PC load enables
//   pc_src                PC source: 0=ALU result, 1=ALUOut register
//   reg_write, result_sel register write enable / writeback source
//   alu_src_a, alu_src_b  ALU operand mux selects
//   alu_op                ALU operation
//   retire                one-cycle pulse per completed instruction
//   instret               retired-instruction counter (wraps)
//   illegal               unsupported-instruction flag (held until rst)

package multicycle_ctrl_pkg;
  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_SUB  = 2'd1,
    ALU_AND  = 2'd2,
    ALU_PASS = 2'd3
  } alu_op_t;
endpackage

module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             result_sel,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output alu_op_t          alu_op,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_EXEC_LUI = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_ALUWB    = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd12;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [3:0]       state_reg;
  logic [3:0]       state_next;
  logic [CNT_W-1:0] instret_reg;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  // Enables before reset gating; reset must silence every side effect
  // immediately, not just from the next edge.
  logic mem_req_c;
  logic ir_write_c;
  logic pc_write_c;
  logic reg_write_c;
  logic retire_c;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    state_next  = state_reg;
    mem_req_c   = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pc_src      = 1'b0;
    reg_write_c = 1'b0;
    result_sel  = 1'b0;
    alu_src_a   = 2'd0;
    alu_src_b   = 2'd0;
    alu_op      = ALU_ADD;
    retire_c    = 1'b0;

    case (state_reg)
      S_FETCH: begin
        mem_req_c = 1'b1;
        alu_src_b = 2'd2;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // oldPC+imm lands in ALUOut as the branch/jump target
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        if ((opcode == OP_LOAD || opcode == OP_STORE) && funct3 == 3'b010)
          state_next = S_MEMADR;
        else if (opcode == OP_REG)
          state_next = S_EXEC_R;
        else if (opcode == OP_IMM)
          state_next = S_EXEC_I;
        else if (opcode == OP_LUI)
          state_next = S_EXEC_LUI;
        else if (opcode == OP_BRANCH && funct3 == 3'b000)
          state_next = S_BRANCH;
        else if (opcode == OP_JAL)
          state_next = S_JAL;
        else
          state_next = S_TRAP;
      end
      S_MEMADR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        // DECODE only lets LW/SW through, so opcode bit 5 separates them
        state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        addr_sel  = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_c = 1'b1;
        result_sel  = 1'b1;
        retire_c    = 1'b1;
        state_next  = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c = 1'b1;
        mem_we    = 1'b1;
        addr_sel  = 1'b1;
        if (mem_ready) begin
          retire_c   = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a  = 2'd2;
        alu_src_b  = 2'd0;
        state_next = S_ALUWB;
        if (funct3 == 3'b000 && funct7 == 7'b0000000)
          alu_op = ALU_ADD;
        else if (funct3 == 3'b000 && funct7 == 7'b0100000)
          alu_op = ALU_SUB;
        else if (funct3 == 3'b111 && funct7 == 7'b0000000)
          alu_op = ALU_AND;
        else
          state_next = S_TRAP;
      end
      S_EXEC_I: begin
        alu_src_a  = 2'd2;
        alu_src_b  = 2'd1;
        state_next = S_ALUWB;
        if (funct3 == 3'b000)
          alu_op = ALU_ADD;
        else if (funct3 == 3'b111)
          alu_op = ALU_AND;
        else
          state_next = S_TRAP;
      end
      S_EXEC_LUI: begin
        alu_src_b  = 2'd1;
        alu_op     = ALU_PASS;
        state_next = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a  = 2'd2;
        alu_src_b  = 2'd0;
        alu_op     = ALU_SUB;
        pc_write_c = zero;
        pc_src     = 1'b1;
        retire_c   = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        // link value oldPC+4 computed now, target taken from ALUOut
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd2;
        pc_write_c = 1'b1;
        pc_src     = 1'b1;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_next  = S_FETCH;
      end
      S_TRAP: begin
        state_next = S_TRAP;
      end
      default: begin
        state_next = S_TRAP;
      end
    endcase
  end

  assign mem_req   = mem_req_c   & ~rst;
  assign ir_write  = ir_write_c  & ~rst;
  assign pc_write  = pc_write_c  & ~rst;
  assign reg_write = reg_write_c & ~rst;
  assign retire    = retire_c    & ~rst;
  assign illegal   = (state_reg == S_TRAP);
  assign instret   = instret_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_FETCH;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire_c) instret_reg <= instret_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl. Each scenario pushes one expected
// record per clock cycle (inputs to apply, expected control outputs and
// expected instret) into a scoreboard queue, then pops and compares them
// cycle by cycle as the DUT runs.

module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int CNT_W = 32;

  localparam int P_FETCH    = 0;
  localparam int P_DECODE   = 1;
  localparam int P_MEMADR   = 2;
  localparam int P_MEMREAD  = 3;
  localparam int P_MEMWB    = 4;
  localparam int P_MEMWRITE = 5;
  localparam int P_EXEC_R   = 6;
  localparam int P_EXEC_I   = 7;
  localparam int P_EXEC_LUI = 8;
  localparam int P_BRANCH   = 9;
  localparam int P_JAL      = 10;
  localparam int P_ALUWB    = 11;
  localparam int P_TRAP     = 12;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_OR   = 32'h0020E1B3;
  localparam logic [31:0] I_ANDI = 32'h0FF0F093;
  localparam logic [31:0] I_LUI  = 32'h123452B7;
  localparam logic [31:0] I_LW   = 32'h0080A283;
  localparam logic [31:0] I_SW   = 32'h0020A423;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic       result_sel;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] op;
    logic       retire;
    logic       illegal;
  } obs_t;

  typedef struct {
    logic [31:0]      instr;
    logic             rdy;
    logic             z;
    obs_t             o;
    logic [CNT_W-1:0] cnt;
    int               ph;
  } entry_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      instr = 32'h0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src;
  logic             reg_write, result_sel, retire, illegal;
  logic [1:0]       alu_src_a, alu_src_b;
  alu_op_t          alu_op;
  logic [CNT_W-1:0] instret;
  obs_t             obs;

  entry_t           sb[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .result_sel(result_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .retire(retire), .instret(instret), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
                reg_write, result_sel, alu_src_a, alu_src_b, alu_op,
                retire, illegal};

  // Expected control outputs for one phase, taken from the state table.
  function automatic obs_t exp_of(int ph, logic rdy, logic z, logic [1:0] op);
    obs_t e = '0;
    case (ph)
      P_FETCH: begin
        e.mem_req = 1'b1; e.src_b = 2'd2;
        e.ir_write = rdy; e.pc_write = rdy;
      end
      P_DECODE:   begin e.src_a = 2'd1; e.src_b = 2'd1; end
      P_MEMADR:   begin e.src_a = 2'd2; e.src_b = 2'd1; end
      P_MEMREAD:  begin e.mem_req = 1'b1; e.addr_sel = 1'b1; end
      P_MEMWB:    begin e.reg_write = 1'b1; e.result_sel = 1'b1; e.retire = 1'b1; end
      P_MEMWRITE: begin
        e.mem_req = 1'b1; e.mem_we = 1'b1; e.addr_sel = 1'b1; e.retire = rdy;
      end
      P_EXEC_R:   begin e.src_a = 2'd2; e.src_b = 2'd0; e.op = op; end
      P_EXEC_I:   begin e.src_a = 2'd2; e.src_b = 2'd1; e.op = op; end
      P_EXEC_LUI: begin e.src_b = 2'd1; e.op = ALU_PASS; end
      P_BRANCH: begin
        e.src_a = 2'd2; e.op = ALU_SUB;
        e.pc_write = z; e.pc_src = 1'b1; e.retire = 1'b1;
      end
      P_JAL: begin
        e.src_a = 2'd1; e.src_b = 2'd2; e.pc_write = 1'b1; e.pc_src = 1'b1;
      end
      P_ALUWB:    begin e.reg_write = 1'b1; e.retire = 1'b1; end
      P_TRAP:     begin e.illegal = 1'b1; end
      default:    e = '0;
    endcase
    return e;
  endfunction

  // Scoreboard producer: queue one cycle of stimulus and its expectation.
  task automatic push(input logic [31:0] ins, input int ph, input logic rdy,
                      input logic z, input logic [1:0] op);
    entry_t en;
    en.instr = ins; en.rdy = rdy; en.z = z; en.ph = ph;
    en.o = exp_of(ph, rdy, z, op);
    en.cnt = exp_cnt;
    sb.push_back(en);
    if (en.o.retire) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b0; zero = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_reset();
    obs_t e;
    rst = 1'b1; mem_ready = 1'b1; instr = I_ADD;
    @(posedge clk); #1;
    // rst still high: FETCH decode but all enables suppressed
    e = exp_of(P_FETCH, 1'b1, 1'b0, ALU_ADD);
    e.mem_req = 1'b0; e.ir_write = 1'b0; e.pc_write = 1'b0;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_outputs: got %h need %h", obs, e);
    end
    checks++;
    if (instret !== '0) begin
      errors++;
      $display("FAIL reset_instret: got %0d need 0", instret);
    end
    $display("reset: outputs %h instret %0d", obs, instret);
    rst = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_add();
    entry_t en;
    push(I_ADD, P_FETCH, 1, 0, ALU_ADD);
    push(I_ADD, P_DECODE, 1, 0, ALU_ADD);
    push(I_ADD, P_EXEC_R, 1, 0, ALU_ADD);
    push(I_ADD, P_ALUWB, 1, 0, ALU_ADD);
    while (sb.size() > 0) begin
      en = sb.pop_front();
      instr = en.instr; mem_ready = en.rdy; zero = en.z; #1;
      checks++;
      if (obs !== en.o) begin
        errors++;
        $display("FAIL add_ph%0d: got %h need %h", en.ph, obs, en.o);
      end
      checks++;
      if (instret !== en.cnt) begin
        errors++;
        $display("FAIL add_instret: got %0d need %0d", instret, en.cnt);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (instret !== 32'd1) begin
      errors++;
      $display("FAIL add_final_instret: got %0d need 1", instret);
    end
    $display("add: instret %0d", instret);
  endtask

  task automatic test_lw_wait();
    entry_t en;
    push(I_LW, P_FETCH, 1, 0, ALU_ADD);
    push(I_LW, P_DECODE, 1, 0, ALU_ADD);
    push(I_LW, P_MEMADR, 1, 0, ALU_ADD);
    push(I_LW, P_MEMREAD, 0, 0, ALU_ADD);
    push(I_LW, P_MEMREAD, 0, 0, ALU_ADD);
    push(I_LW, P_MEMREAD, 1, 0, ALU_ADD);
    push(I_LW, P_MEMWB, 1, 0, ALU_ADD);
    while (sb.size() > 0) begin
      en = sb.pop_front();
      instr = en.instr; mem_ready = en.rdy; zero = en.z; #1;
      checks++;
      if (obs !== en.o) begin
        errors++;
        $display("FAIL lw_ph%0d: got %h need %h", en.ph, obs, en.o);
      end
      checks++;
      if (instret !== en.cnt) begin
        errors++;
        $display("FAIL lw_instret: got %0d need %0d", instret, en.cnt);
      end
      @(posedge clk); #1;
    end
    $display("lw_wait: instret %0d", instret);
  endtask

  task automatic test_branch();
    entry_t en;
    push(I_BEQ, P_FETCH, 1, 0, ALU_ADD);
    push(I_BEQ, P_DECODE, 1, 0, ALU_ADD);
    push(I_BEQ, P_BRANCH, 1, 1, ALU_SUB);
    push(I_BEQ, P_FETCH, 1, 0, ALU_ADD);
    push(I_BEQ, P_DECODE, 1, 0, ALU_ADD);
    push(I_BEQ, P_BRANCH, 1, 0, ALU_SUB);
    while (sb.size() > 0) begin
      en = sb.pop_front();
      instr = en.instr; mem_ready = en.rdy; zero = en.z; #1;
      checks++;
      if (obs !== en.o) begin
        errors++;
        $display("FAIL beq_ph%0d_z%0d: got %h need %h", en.ph, en.z, obs, en.o);
      end
      checks++;
      if (instret !== en.cnt) begin
        errors++;
        $display("FAIL beq_instret: got %0d need %0d", instret, en.cnt);
      end
      @(posedge clk); #1;
    end
    zero = 1'b0;
    $display("branch: instret %0d", instret);
  endtask

  task automatic test_alu_ops();
    entry_t en;
    push(I_SUB, P_FETCH, 1, 0, ALU_ADD);
    push(I_SUB, P_DECODE, 1, 0, ALU_ADD);
    push(I_SUB, P_EXEC_R, 1, 0, ALU_SUB);
    push(I_SUB, P_ALUWB, 1, 0, ALU_ADD);
    push(I_ANDI, P_FETCH, 1, 0, ALU_ADD);
    push(I_ANDI, P_DECODE, 1, 0, ALU_ADD);
    push(I_ANDI, P_EXEC_I, 1, 0, ALU_AND);
    push(I_ANDI, P_ALUWB, 1, 0, ALU_ADD);
    push(I_LUI, P_FETCH, 1, 0, ALU_ADD);
    push(I_LUI, P_DECODE, 1, 0, ALU_ADD);
    push(I_LUI, P_EXEC_LUI, 1, 0, ALU_PASS);
    push(I_LUI, P_ALUWB, 1, 0, ALU_ADD);
    while (sb.size() > 0) begin
      en = sb.pop_front();
      instr = en.instr; mem_ready = en.rdy; zero = en.z; #1;
      checks++;
      if (obs !== en.o) begin
        errors++;
        $display("FAIL aluop_%h_ph%0d: got %h need %h", en.instr, en.ph, obs, en.o);
      end
      checks++;
      if (instret !== en.cnt) begin
        errors++;
        $display("FAIL aluop_instret: got %0d need %0d", instret, en.cnt);
      end
      @(posedge clk); #1;
    end
    $display("alu_ops: instret %0d", instret);
  endtask

  task automatic test_back_to_back();
    entry_t en;
    // SW with one wait cycle, then JAL, then LW, all without idle gaps
    push(I_SW, P_FETCH, 0, 0, ALU_ADD);
    push(I_SW, P_FETCH, 1, 0, ALU_ADD);
    push(I_SW, P_DECODE, 1, 0, ALU_ADD);
    push(I_SW, P_MEMADR, 1, 0, ALU_ADD);
    push(I_SW, P_MEMWRITE, 0, 0, ALU_ADD);
    push(I_SW, P_MEMWRITE, 1, 0, ALU_ADD);
    push(I_JAL, P_FETCH, 1, 0, ALU_ADD);
    push(I_JAL, P_DECODE, 1, 0, ALU_ADD);
    push(I_JAL, P_JAL, 1, 0, ALU_ADD);
    push(I_JAL, P_ALUWB, 1, 0, ALU_ADD);
    push(I_LW, P_FETCH, 1, 0, ALU_ADD);
    push(I_LW, P_DECODE, 1, 0, ALU_ADD);
    push(I_LW, P_MEMADR, 1, 0, ALU_ADD);
    push(I_LW, P_MEMREAD, 1, 0, ALU_ADD);
    push(I_LW, P_MEMWB, 1, 0, ALU_ADD);
    while (sb.size() > 0) begin
      en = sb.pop_front();
      instr = en.instr; mem_ready = en.rdy; zero = en.z; #1;
      checks++;
      if (obs !== en.o) begin
        errors++;
        $display("FAIL b2b_%h_ph%0d: got %h need %h", en.instr, en.ph, obs, en.o);
      end
      checks++;
      if (instret !== en.cnt) begin
        errors++;
        $display("FAIL b2b_instret: got %0d need %0d", instret, en.cnt);
      end
      @(posedge clk); #1;
    end
    $display("back_to_back: instret %0d", instret);
  endtask

  task automatic test_trap();
    entry_t en;
    obs_t   e;
    push(I_BAD, P_FETCH, 1, 0, ALU_ADD);
    push(I_BAD, P_DECODE, 1, 0, ALU_ADD);
    for (int i = 0; i < 20; i++) push(I_BAD, P_TRAP, (i % 2 == 0), 0, ALU_ADD);
    while (sb.size() > 0) begin
      en = sb.pop_front();
      instr = en.instr; mem_ready = en.rdy; zero = en.z; #1;
      checks++;
      if (obs !== en.o) begin
        errors++;
        $display("FAIL trap_ph%0d: got %h need %h", en.ph, obs, en.o);
      end
      checks++;
      if (instret !== en.cnt) begin
        errors++;
        $display("FAIL trap_instret: got %0d need %0d", instret, en.cnt);
      end
      @(posedge clk); #1;
    end
    do_reset();
    mem_ready = 1'b0; #1;
    e = exp_of(P_FETCH, 1'b0, 1'b0, ALU_ADD);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL trap_cleared: got %h need %h", obs, e);
    end
    @(posedge clk); #1;
    // unsupported R-type funct3 traps from EXEC_R
    push(I_OR, P_FETCH, 1, 0, ALU_ADD);
    push(I_OR, P_DECODE, 1, 0, ALU_ADD);
    push(I_OR, P_EXEC_R, 1, 0, ALU_ADD);
    push(I_OR, P_TRAP, 1, 0, ALU_ADD);
    push(I_OR, P_TRAP, 1, 0, ALU_ADD);
    while (sb.size() > 0) begin
      en = sb.pop_front();
      instr = en.instr; mem_ready = en.rdy; zero = en.z; #1;
      checks++;
      if (obs !== en.o) begin
        errors++;
        $display("FAIL rtrap_ph%0d: got %h need %h", en.ph, obs, en.o);
      end
      @(posedge clk); #1;
    end
    do_reset();
    $display("trap: illegal %0d after reset", illegal);
  endtask

  task automatic test_rst_abort();
    entry_t en;
    obs_t   e;
    do_reset();
    push(I_SW, P_FETCH, 1, 0, ALU_ADD);
    push(I_SW, P_DECODE, 1, 0, ALU_ADD);
    push(I_SW, P_MEMADR, 1, 0, ALU_ADD);
    push(I_SW, P_MEMWRITE, 0, 0, ALU_ADD);
    while (sb.size() > 0) begin
      en = sb.pop_front();
      instr = en.instr; mem_ready = en.rdy; zero = en.z; #1;
      checks++;
      if (obs !== en.o) begin
        errors++;
        $display("FAIL abort_ph%0d: got %h need %h", en.ph, obs, en.o);
      end
      @(posedge clk); #1;
    end
    // reset during the store wait: request and retire drop at once
    rst = 1'b1; mem_ready = 1'b0; #1;
    e = exp_of(P_MEMWRITE, 1'b0, 1'b0, ALU_ADD);
    e.mem_req = 1'b0;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL abort_in_rst: got %h need %h", obs, e);
    end
    @(posedge clk); #1;
    rst = 1'b0; #1;
    e = exp_of(P_FETCH, 1'b0, 1'b0, ALU_ADD);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL abort_refetch: got %h need %h", obs, e);
    end
    checks++;
    if (instret !== '0) begin
      errors++;
      $display("FAIL abort_instret: got %0d need 0", instret);
    end
    $display("rst_abort: outputs %h instret %0d", obs, instret);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_alu_ops();
    test_back_to_back();
    test_trap();
    test_rst_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got cycle %0d need completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
